// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder emulating a 25xx serial EEPROM (READ 0x03, 8-bit address, auto-increment).
// Define SPI_EEPROM_WRITE_EN to add WREN/WRDI/RDSR/WRITE with 16-byte page wrap.
module spi_eeprom_responder #(
    parameter int DEPTH       = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       copi,
    output logic       cipo,
    output logic       cipo_oe,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       busy,
    output logic [7:0] cur_addr
);
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
`ifdef SPI_EEPROM_WRITE_EN
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WREN  = 8'h06;
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, READ, DISCARD
`ifdef SPI_EEPROM_WRITE_EN
        , WRITE, RDSR
`endif
    } state_t;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] rx_sr, rx_n, rx_next;
    logic [7:0] tx_sr, tx_n;
    logic [7:0] addr_n;
    logic       cipo_n, oe_n;
    logic       reload, reload_n;
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_addr, rd_data;
    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata;
`ifdef SPI_EEPROM_WRITE_EN
    logic       wel, wel_n;
    logic       cmd_wr, cmd_wr_n;
    logic [7:0] status;
`endif

    // Pin synchronizers plus one extra stage for edge detection; not reset so that
    // a cs_n held low across rst cannot produce a spurious cs_fall afterwards.
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, copi_sync;
    logic sck_d, sck_q, cs_d, cs_q, copi_d;

    always_ff @(posedge clk) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
        sck_d     <= sck_sync[SYNC_STAGES-1];
        cs_d      <= cs_sync[SYNC_STAGES-1];
        copi_d    <= copi_sync[SYNC_STAGES-1];
        sck_q     <= sck_d;
        cs_q      <= cs_d;
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    assign sck_rise = sck_d & ~sck_q;
    assign sck_fall = ~sck_d & sck_q;
    assign cs_fall  = ~cs_d & cs_q;
    assign cs_rise  = cs_d & ~cs_q;

    assign busy       = ((state != IDLE) | cs_fall) & ~cs_rise;
    assign load_ready = cs_d & ~busy;

    assign rx_next = {rx_sr[6:0], copi_d};
    assign rd_addr = (state == ADDR) ? rx_next : cur_addr;
    assign rd_data = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : 8'hFF;
`ifdef SPI_EEPROM_WRITE_EN
    assign status  = {6'b0, wel, 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd7;
            rx_sr    <= 8'h00;
            tx_sr    <= 8'h00;
            cur_addr <= 8'h00;
            cipo     <= 1'b1;
            cipo_oe  <= 1'b0;
            reload   <= 1'b0;
`ifdef SPI_EEPROM_WRITE_EN
            wel      <= 1'b0;
            cmd_wr   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx_sr    <= rx_n;
            tx_sr    <= tx_n;
            cur_addr <= addr_n;
            cipo     <= cipo_n;
            cipo_oe  <= oe_n;
            reload   <= reload_n;
`ifdef SPI_EEPROM_WRITE_EN
            wel      <= wel_n;
            cmd_wr   <= cmd_wr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        rx_n      = rx_sr;
        tx_n      = tx_sr;
        addr_n    = cur_addr;
        cipo_n    = cipo;
        oe_n      = cipo_oe;
        reload_n  = 1'b0;
        mem_we    = load_en & load_ready;
        mem_waddr = load_addr;
        mem_wdata = load_data;
`ifdef SPI_EEPROM_WRITE_EN
        wel_n     = wel;
        cmd_wr_n  = cmd_wr;
`endif
        // cs_rise overrides any SCK edge seen in the same cycle
        if (cs_rise) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd7;
            cipo_n    = 1'b1;
            oe_n      = 1'b0;
`ifdef SPI_EEPROM_WRITE_EN
            if (cmd_wr) wel_n = 1'b0;
            cmd_wr_n = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_n   = CMD;
                        bit_cnt_n = 3'd7;
`ifdef SPI_EEPROM_WRITE_EN
                        cmd_wr_n  = 1'b0;
`endif
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_n      = rx_next;
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            case (rx_next)
                                CMD_READ: state_n = ADDR;
`ifdef SPI_EEPROM_WRITE_EN
                                CMD_WRITE: begin
                                    state_n  = ADDR;
                                    cmd_wr_n = 1'b1;
                                end
                                CMD_WREN: begin
                                    wel_n   = 1'b1;
                                    state_n = DISCARD;
                                end
                                CMD_WRDI: begin
                                    wel_n   = 1'b0;
                                    state_n = DISCARD;
                                end
                                CMD_RDSR: begin
                                    tx_n    = status;
                                    state_n = RDSR;
                                end
`endif
                                default: state_n = DISCARD;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        rx_n      = rx_next;
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            addr_n    = rx_next;
                            tx_n      = rd_data;
                            state_n   = READ;
`ifdef SPI_EEPROM_WRITE_EN
                            if (cmd_wr) state_n = wel ? WRITE : DISCARD;
`endif
                        end
                    end
                end
                READ: begin
                    if (reload) begin
                        tx_n = rd_data;
                    end else if (sck_fall) begin
                        cipo_n    = tx_sr[7];
                        tx_n      = {tx_sr[6:0], 1'b0};
                        oe_n      = 1'b1;
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            addr_n    = cur_addr + 8'd1;
                            reload_n  = 1'b1;
                        end
                    end
                end
                DISCARD: oe_n = 1'b0;
`ifdef SPI_EEPROM_WRITE_EN
                WRITE: begin
                    if (sck_rise) begin
                        rx_n      = rx_next;
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            mem_we    = 1'b1;
                            mem_waddr = cur_addr;
                            mem_wdata = rx_next;
                            addr_n    = {cur_addr[7:4], cur_addr[3:0] + 4'd1};
                        end
                    end
                end
                RDSR: begin
                    if (reload) begin
                        tx_n = status;
                    end else if (sck_fall) begin
                        cipo_n    = tx_sr[7];
                        tx_n      = {tx_sr[6:0], 1'b0};
                        oe_n      = 1'b1;
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            reload_n  = 1'b1;
                        end
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (mem_we && ({1'b0, mem_waddr} < DEPTH_W))
            mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Self-checking bench for spi_eeprom_responder: bit-banged SPI initiator with a read-data scoreboard.
module tb_spi_eeprom_responder;
    logic       clk = 1'b0, rst = 1'b1;
    logic       sck = 1'b0, cs_n = 1'b1, copi = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'h00, load_data = 8'h00;
    logic       cipo, cipo_oe, load_ready, busy;
    logic [7:0] cur_addr;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] mdl [256];
    logic [7:0] exp_q [$];
    logic       oe_seen;
    logic [7:0] rb;

    always #5 clk = ~clk;

    spi_eeprom_responder dut (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .busy(busy), .cur_addr(cur_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        mdl[a] = d;
    endtask

    // One SCK period: 5 clk low, 5 clk high; cipo sampled at the rising edge
    task automatic xfer_bit(input logic b, output logic r);
        copi = b;
        wait_clk(5);
        r = cipo;
        oe_seen = oe_seen | cipo_oe;
        sck = 1'b1;
        wait_clk(5);
        sck = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_hi();
        wait_clk(5);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic read_bytes(input logic [7:0] addr, input int n, input string tag);
        logic [7:0] r;
        logic [7:0] a;
        a = addr;
        cs_lo();
        xfer_byte(8'h03, r);
        xfer_byte(addr, r);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mdl[a]);
            a = a + 8'd1;
            xfer_byte(8'h00, r);
            chk(tag, 32'(r), 32'(exp_q.pop_front()));
        end
        cs_hi();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic b;
        oe_seen = 1'b0;
        wait_clk(6);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_cipo", 32'(cipo), 32'd1);
        chk("rst_cipo_oe", 32'(cipo_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_cur_addr", 32'(cur_addr), 32'h00);

        load(8'h00, 8'h10);
        load(8'h01, 8'h3F);
        read_bytes(8'h00, 2, "rd_seq");
        chk("rd_seq_addr", 32'(cur_addr), 32'h02);

        load(8'hFF, 8'hA5);
        load(8'h00, 8'h5A);
        read_bytes(8'hFF, 2, "rd_wrap");
        chk("rd_wrap_addr", 32'(cur_addr), 32'h01);

        // Unsupported command: never drives, busy clears within SYNC_STAGES+1 clk
        oe_seen = 1'b0;
        cs_lo();
        chk("unsup_busy", 32'(busy), 32'd1);
        chk("unsup_load_ready", 32'(load_ready), 32'd0);
        xfer_byte(8'h9F, rb);
        xfer_byte(8'h00, rb);
        xfer_byte(8'h00, rb);
        chk("unsup_oe", 32'(oe_seen), 32'd0);
        wait_clk(5);
        cs_n = 1'b1;
        wait_clk(2);
        chk("unsup_busy_hold", 32'(busy), 32'd1);
        wait_clk(1);
        chk("unsup_busy_drop", 32'(busy), 32'd0);
        chk("unsup_load_ready", 32'(load_ready), 32'd1);
        wait_clk(5);

        // Aborted byte after 4 data bits leaves no residue
        cs_lo();
        xfer_byte(8'h03, rb);
        xfer_byte(8'h00, rb);
        for (int i = 0; i < 4; i++) xfer_bit(1'b0, b);
        cs_hi();
        read_bytes(8'h01, 1, "rd_after_abort");

        // Reset mid-READ with cs_n held low
        cs_lo();
        xfer_byte(8'h03, rb);
        xfer_byte(8'h00, rb);
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, b);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(2);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_oe", 32'(cipo_oe), 32'd0);
        chk("midrst_cipo", 32'(cipo), 32'd1);
        oe_seen = 1'b0;
        xfer_byte(8'h00, rb);
        chk("midrst_oe_sck", 32'(oe_seen), 32'd0);
        chk("midrst_busy_sck", 32'(busy), 32'd0);
        cs_hi();
        read_bytes(8'h00, 1, "rd_after_rst");

`ifdef SPI_EEPROM_WRITE_EN
        load(8'h20, 8'h11);
        cs_lo(); xfer_byte(8'h06, rb); cs_hi();
        cs_lo();
        xfer_byte(8'h02, rb); xfer_byte(8'h1F, rb);
        xfer_byte(8'hC3, rb); xfer_byte(8'h3C, rb);
        cs_hi();
        mdl[8'h1F] = 8'hC3;
        mdl[8'h10] = 8'h3C;
        read_bytes(8'h1F, 1, "wr_byte");
        read_bytes(8'h10, 1, "wr_page_wrap");
        cs_lo();
        xfer_byte(8'h05, rb);
        exp_q.push_back(8'h00);
        xfer_byte(8'h00, rb);
        chk("rdsr_after_write", 32'(rb), 32'(exp_q.pop_front()));
        cs_hi();
        cs_lo();
        xfer_byte(8'h02, rb); xfer_byte(8'h20, rb); xfer_byte(8'h77, rb);
        cs_hi();
        read_bytes(8'h20, 1, "wr_no_wel");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
